onehot_encoder_pipe: RTL and testbench
======================================

// Module: onehot_encoder_pipe
// PURPOSE
//  Registered one-hot-to-binary encoder: the inverse of the team's N-to-2^N decoders.
//  Accepts a 2^N-bit vector over a valid/ready handshake and emits its binary index one cycle later.
//  Also flags all-zero and multi-hot inputs, and keeps saturating word and error counters.
//  Sits downstream of decoder/flip-flop datapaths, so a bench or upstream logic can round-trip decoded values.
// PARAMETERS
//  SEL_W   3    index width N; input vector width IN_W = 2**SEL_W
//  CNT_W   8    width of the word and error counters
// PORTS
//  clk        in   1       single clock, all state updates on posedge
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       upstream has a vector on in_vec
//  in_ready   out  1       block can accept this cycle
//  in_vec     in   IN_W    one-hot vector to encode
//  out_valid  out  1       out_* fields hold an encoded result
//  out_ready  in   1       downstream accepts the result this cycle
//  out_idx    out  SEL_W   index of highest set bit; 0 when vector is zero
//  out_zero   out  1       no bit set in the source vector
//  out_multi  out  1       more than one bit set in the source vector
//  cnt_words  out  CNT_W   results delivered (out handshakes), saturating
//  cnt_errs   out  CNT_W   delivered results with out_zero|out_multi, saturating
// BEHAVIOUR
//  - Reset, sampled on posedge clk while reset=1:
//    - all state cleared; out_valid=0, out_idx=0, out_zero=0, out_multi=0, cnt_*=0.
//    - in_ready=0 while reset is high; in_ready=1 on the first cycle after reset drops.
//  - Handshakes:
//    - input transfer = in_valid & in_ready at a posedge.
//    - output transfer = out_valid & out_ready at a posedge.
//    - out_* fields stay stable while out_valid=1 and out_ready=0.
//  - Encode: priority to the highest set bit.
//    - Example 8'b0010_0100 -> idx=5, multi=1.
//    - 8'h00 -> idx=0, zero=1, multi=0.
//  - Storage: 2-entry skid buffer; main register OUT drives the out_* ports, SKID is the overflow entry.
//    - in_ready = ~reset & ~skid_full; it is a registered-state function and has no combinational path from out_ready.
//  - States:
//    - EMPTY: out_valid=0, in_ready=1.
//    - ONE: OUT full.
//    - TWO: OUT and SKID full, in_ready=0.
//  - Transitions:
//    - EMPTY + in xfer -> ONE. Latency is 1 cycle: the vector accepted at edge k is on the outputs after edge k.
//    - ONE + in xfer + out xfer -> ONE, OUT <= new vector (full throughput, 1 word/cycle).
//    - ONE + in xfer, no out xfer -> TWO, SKID <= new vector.
//    - ONE + out xfer only -> EMPTY.
//    - TWO + out xfer -> ONE, OUT <= SKID. No input is accepted in TWO.
//    - Otherwise hold.
//  - Ordering: strict FIFO, never drops or duplicates a word.
//  - Counters, updated at each out xfer:
//    - cnt_words += 1.
//    - cnt_errs += 1 if out_zero|out_multi.
//    - both saturate at 2**CNT_W-1 (255) and never wrap.
//  - Reset mid-operation: any buffered words are discarded and counters are cleared. Reset overrides a simultaneous handshake.
// STRUCTURE
//  - Shared package: SEL_W/CNT_W defaults, the state encoding constants (EMPTY/ONE/TWO = 2'd0/1/2),
//    and an encode-result record type {idx, zero, multi}.
//  - Sub-module: onehot_prio_enc, a combinational IN_W -> {idx, zero, multi} encoder.
//    It is instantiated once on the input path, so both OUT and SKID store encoded results.
//  - Top level: skid buffer, FSM, counters.
// TESTING
//  - Reset:
//    - Stimulus: reset=1 for 100 ns, then release.
//    - Required: all outputs 0 during reset; first cycle after release: in_ready=1, out_valid=0, cnt_words=0.
//  - Single encode:
//    - Stimulus: in_vec=8'h20, one in xfer, out_ready=1.
//    - Required: next cycle out_idx=5, out_zero=0, out_multi=0; then cnt_words=1, cnt_errs=0.
//  - Streaming:
//    - Stimulus: vectors 8'h01,02,04,...,80 on back-to-back cycles, out_ready=1.
//    - Required: out_idx 0..7 on consecutive cycles; in_ready stays 1; cnt_words=8.
//  - Backpressure:
//    - Stimulus: out_ready=0; offer 8'h02, 8'h40, 8'h08.
//    - Required: first two accepted, in_ready=0, out_idx held at 1.
//    - Then out_ready=1: outputs 1, 6, 3 in order, none lost.
//  - Error flags:
//    - Stimulus: send 8'h00 and 8'h24, both delivered.
//    - Required: (idx=0, zero=1) and (idx=5, multi=1); cnt_errs=2.
//  - Saturation and mid-run reset:
//    - Stimulus: deliver 300 words with out_zero.
//    - Required: cnt_words=255, cnt_errs=255.
//    - Then assert reset while in TWO: out_valid=0, counters=0, and buffered words never appear.

Source files
------------

// File: rtl/onehot_encoder_pipe_pkg.sv
// Shared types and constants for the one-hot encoder pipeline.
// The default widths here are used by the top level and its consumers.
package onehot_encoder_pipe_pkg;

  localparam int DEF_SEL_W = 3;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Encode result at the default index width.
  typedef struct packed {
    logic [DEF_SEL_W-1:0] idx;
    logic                 zero;
    logic                 multi;
  } enc_res_t;

endpackage

// File: rtl/onehot_encoder_pipe_prio_enc.sv
// Combinational 2^N -> N priority encoder; the highest set bit wins.
// Also reports empty and multi-hot vectors.
module onehot_prio_enc #(
  parameter int SEL_W = 3,
  localparam int IN_W = 1 << SEL_W
) (
  input  logic [IN_W-1:0]  i_vec,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_zero,
  output logic             o_multi
);

  logic w_seen;

  // Upward scan: each later set bit overwrites the index, so the top one sticks.
  always_comb begin
    o_idx   = '0;
    o_multi = 1'b0;
    w_seen  = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (i_vec[i]) begin
        o_multi = o_multi | w_seen;
        w_seen  = 1'b1;
        o_idx   = SEL_W'(i);
      end
    end
    o_zero = ~w_seen;
  end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Registered one-hot-to-binary encoder behind a 2-entry skid buffer,
// with saturating delivered-word and error counters.
module onehot_encoder_pipe
  import onehot_encoder_pipe_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W,
  localparam int IN_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_multi,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_errs
);

  typedef struct packed {
    logic [SEL_W-1:0] idx;
    logic             zero;
    logic             multi;
  } res_t;

  state_e           r_state;
  res_t             r_out;
  res_t             r_skid;
  logic [CNT_W-1:0] r_cnt_words;
  logic [CNT_W-1:0] r_cnt_errs;

  res_t w_enc;
  logic w_in_xfer;
  logic w_out_xfer;

  // Encoding happens before storage, so both entries hold finished results.
  onehot_prio_enc #(.SEL_W(SEL_W)) u_enc (
    .i_vec   (in_vec),
    .o_idx   (w_enc.idx),
    .o_zero  (w_enc.zero),
    .o_multi (w_enc.multi)
  );

  // Ready depends only on held state, never on out_ready.
  assign in_ready   = ~reset & (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  assign out_idx   = r_out.idx;
  assign out_zero  = r_out.zero;
  assign out_multi = r_out.multi;
  assign cnt_words = r_cnt_words;
  assign cnt_errs  = r_cnt_errs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_out       <= '0;
      r_skid      <= '0;
      r_cnt_words <= '0;
      r_cnt_errs  <= '0;
    end else begin
      if (w_out_xfer) begin
        if (r_cnt_words != '1)
          r_cnt_words <= r_cnt_words + CNT_W'(1);
        if ((r_out.zero | r_out.multi) && (r_cnt_errs != '1))
          r_cnt_errs <= r_cnt_errs + CNT_W'(1);
      end

      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_out   <= w_enc;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_out <= w_enc;
          end else if (w_in_xfer) begin
            r_skid  <= w_enc;
            r_state <= ST_TWO;
          end else if (w_out_xfer) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            r_out   <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Self-checking bench for onehot_encoder_pipe against a queue-based model.
module tb_onehot_encoder_pipe;
  import onehot_encoder_pipe_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_zero;
  logic       out_multi;
  logic [7:0] cnt_words;
  logic [7:0] cnt_errs;

  onehot_encoder_pipe #(.SEL_W(3), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_multi (out_multi),
    .cnt_words (cnt_words),
    .cnt_errs  (cnt_errs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  enc_res_t q[$];
  int       m_words;
  int       m_errs;
  bit       g_oxf;
  int       n_vec;
  int       n_err;

  // Reference: zero/multi by bit count, index of highest bit by log2.
  function automatic enc_res_t ref_enc(input int v);
    enc_res_t r;
    r.zero  = (v == 0);
    r.multi = ($countones(v) > 1);
    r.idx   = (v == 0) ? 3'd0 : 3'($clog2(v + 1) - 1);
    return r;
  endfunction

  // Drive one cycle and advance the model as a 2-deep FIFO.
  task automatic step(input logic [7:0] v, input bit iv, input bit ordy);
    bit       ixf;
    bit       oxf;
    enc_res_t h;
    in_vec    = v;
    in_valid  = iv;
    out_ready = ordy;
    ixf = iv && (q.size() < 2) && !reset;
    oxf = ordy && (q.size() > 0) && !reset;
    g_oxf = oxf;
    if (oxf) begin
      h = q.pop_front();
      if (m_words < 255) m_words++;
      if ((h.zero || h.multi) && m_errs < 255) m_errs++;
    end
    if (ixf) q.push_back(ref_enc(int'(v)));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    q.delete(); m_words = 0; m_errs = 0;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_idx, out_zero, out_multi, cnt_words, cnt_errs} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {in_ready, out_valid, out_idx, out_zero, out_multi, cnt_words, cnt_errs});
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cnt_words !== 8'd0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b vld=%b words=%0d expected 1 0 0",
               in_ready, out_valid, cnt_words);
    end
  endtask

  task automatic test_single;
    step(8'h20, 1'b1, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_zero !== 1'b0 || out_multi !== 1'b0) begin
      n_err++;
      $display("FAIL single_encode: got v=%b i=%0d z=%b m=%b expected 1 5 0 0",
               out_valid, out_idx, out_zero, out_multi);
    end
    step(8'h00, 1'b0, 1'b1);
    n_vec++;
    if (cnt_words !== 8'd1 || cnt_errs !== 8'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_counters: got w=%0d e=%0d v=%b expected 1 0 0",
               cnt_words, cnt_errs, out_valid);
    end
  endtask

  task automatic test_stream;
    int base;
    base = m_words;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready);
      end
      step(8'(1 << i), 1'b1, 1'b1);
      n_vec++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i)) begin
        n_err++;
        $display("FAIL stream_idx[%0d]: got v=%b i=%0d expected 1 %0d", i, out_valid, out_idx, i);
      end
    end
    step(8'h00, 1'b0, 1'b1);
    n_vec++;
    if (cnt_words !== 8'(base + 8)) begin
      n_err++;
      $display("FAIL stream_words: got %0d expected %0d", cnt_words, base + 8);
    end
  endtask

  task automatic test_backpressure;
    int got[$];
    bit pend;
    int cyc;
    step(8'h02, 1'b1, 1'b0);
    step(8'h40, 1'b1, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 3'd1) begin
      n_err++;
      $display("FAIL bp_full: got rdy=%b v=%b i=%0d expected 0 1 1", in_ready, out_valid, out_idx);
    end
    step(8'h08, 1'b1, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || out_idx !== 3'd1) begin
      n_err++;
      $display("FAIL bp_hold: got rdy=%b i=%0d expected 0 1", in_ready, out_idx);
    end
    pend = 1'b1;
    cyc  = 0;
    while ((pend || out_valid) && cyc < 10) begin
      if (out_valid) got.push_back(int'(out_idx));
      if (pend && q.size() < 2) begin
        step(8'h08, 1'b1, 1'b1);
        pend = 1'b0;
      end else begin
        step(8'h08, pend, 1'b1);
      end
      cyc++;
    end
    n_vec++;
    if (got.size() != 3 || got[0] != 1 || got[1] != 6 || got[2] != 3) begin
      n_err++;
      $display("FAIL bp_order: got %p expected '{1, 6, 3}", got);
    end
  endtask

  task automatic test_errors;
    int e0;
    e0 = m_errs;
    step(8'h00, 1'b1, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_zero !== 1'b1 || out_multi !== 1'b0) begin
      n_err++;
      $display("FAIL err_zero: got v=%b i=%0d z=%b m=%b expected 1 0 1 0",
               out_valid, out_idx, out_zero, out_multi);
    end
    step(8'h24, 1'b1, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_zero !== 1'b0 || out_multi !== 1'b1) begin
      n_err++;
      $display("FAIL err_multi: got v=%b i=%0d z=%b m=%b expected 1 5 0 1",
               out_valid, out_idx, out_zero, out_multi);
    end
    step(8'h00, 1'b0, 1'b1);
    n_vec++;
    if (cnt_errs !== 8'(e0 + 2)) begin
      n_err++;
      $display("FAIL err_count: got %0d expected %0d", cnt_errs, e0 + 2);
    end
  endtask

  task automatic test_random;
    logic [7:0] v;
    int         k;
    for (int c = 0; c < 300; c++) begin
      n_vec++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) ||
          cnt_words !== 8'(m_words) || cnt_errs !== 8'(m_errs)) begin
        n_err++;
        $display("FAIL rand_ctrl[%0d]: got rdy=%b v=%b w=%0d e=%0d expected %b %b %0d %0d",
                 c, in_ready, out_valid, cnt_words, cnt_errs,
                 q.size() < 2, q.size() > 0, m_words, m_errs);
      end
      if (q.size() > 0) begin
        n_vec++;
        if ({out_idx, out_zero, out_multi} !== q[0]) begin
          n_err++;
          $display("FAIL rand_data[%0d]: got %0h expected %0h", c, {out_idx, out_zero, out_multi}, q[0]);
        end
      end
      k = int'($urandom % 4);
      if (k == 0)      v = 8'h00;
      else if (k == 1) v = 8'($urandom);
      else             v = 8'(1 << ($urandom % 8));
      step(v, ($urandom % 4) != 0, ($urandom % 3) != 0);
    end
  endtask

  task automatic test_saturation;
    int delivered;
    int cyc;
    delivered = 0;
    cyc = 0;
    while (delivered < 300 && cyc < 5000) begin
      if (q.size() > 0) begin
        n_vec++;
        if (out_valid !== 1'b1 || {out_idx, out_zero, out_multi} !== q[0]) begin
          n_err++;
          $display("FAIL sat_data[%0d]: got v=%b %0h expected 1 %0h",
                   cyc, out_valid, {out_idx, out_zero, out_multi}, q[0]);
        end
      end
      step(8'h00, ($urandom % 4) != 0, ($urandom % 4) != 0);
      if (g_oxf) delivered++;
      cyc++;
    end
    if (cyc >= 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL sat_timeout: got %0d delivered expected 300", delivered);
    end
    n_vec++;
    if (cnt_words !== 8'd255 || cnt_errs !== 8'd255) begin
      n_err++;
      $display("FAIL sat_counters: got w=%0d e=%0d expected 255 255", cnt_words, cnt_errs);
    end
  endtask

  task automatic test_mid_reset;
    step(8'h10, 1'b1, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mrst_two: got rdy=%b v=%b expected 0 1", in_ready, out_valid);
    end
    in_vec = 8'h01; in_valid = 1'b1; out_ready = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete(); m_words = 0; m_errs = 0;
    n_vec++;
    if (out_valid !== 1'b0 || cnt_words !== 8'd0 || cnt_errs !== 8'd0 ||
        in_ready !== 1'b0 || out_idx !== 3'd0) begin
      n_err++;
      $display("FAIL mrst_clear: got v=%b w=%0d e=%0d rdy=%b i=%0d expected 0 0 0 0 0",
               out_valid, cnt_words, cnt_errs, in_ready, out_idx);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(8'h00, 1'b0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_words !== 8'd0) begin
        n_err++;
        $display("FAIL mrst_drain[%0d]: got v=%b rdy=%b w=%0d expected 0 1 0",
                 c, out_valid, in_ready, cnt_words);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    g_oxf = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_errors();
    test_random();
    test_saturation();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
